frame_output_ctrl: RTL
======================

// Module: frame_output_ctrl
// PURPOSE
//  Parametrised frame-buffer output stage of the SimpleGPU pipeline, between the alpha blender/texture controller and the
//  SDRAM Avalon-MM master port. Holds one frame in an on-chip dual-port RAM and serves blender read/write by pixel number.
//  On frame_ready, streams the whole frame to SDRAM with waitrequest back-pressure, pulses frame_done, then returns to blending.
// PARAMETERS
//  PIXEL_W     24        pixel width, packed {b[23:16],g[15:8],r[7:0]}
//  NUM_PIXELS  76800     pixels per frame (320x240)
//  ADDR_W      17        pixel index width; $clog2(NUM_PIXELS) <= ADDR_W
//  SD_ADDR_W   26        SDRAM byte-address width
//  SD_DATA_W   32        SDRAM data width; pixel zero-extended into LSBs
//  SD_BASE     26'h0     SDRAM byte address of pixel 0 (frame A)
//  SD_BASE_B   26'h80000 second frame base, used only with OUTCTRL_DBLBUF_EN
// PORTS
//  clk           in   1          system clock
//  rst           in   1          asynchronous reset, active-high
//  pixel_number  in   ADDR_W     pixel index for blend read/write
//  blend_write   in   1          write blend_wdata to pixel_number
//  blend_wdata   in   PIXEL_W    blended pixel
//  blend_read    in   1          read pixel_number
//  read_rdata    out  PIXEL_W    read data, valid with read_valid
//  read_valid    out  1          one-cycle pulse, 1 clk after accepted blend_read
//  frame_ready   in   1          pulse: frame complete, start drain
//  busy          out  1          high in any non-BLEND state
//  frame_done    out  1          one-cycle pulse at end of drain
//  drop_err      out  1          sticky: blend access ignored during drain/out-of-range
//  sd_write      out  1          Avalon write request
//  sd_address    out  SD_ADDR_W  Avalon byte address
//  sd_wdata      out  SD_DATA_W  Avalon write data
//  sd_waitrequest in  1          Avalon stall
// BEHAVIOUR
//  Reset: state=BLEND; all outputs 0; drain index 0; pixel RAM contents undefined (not cleared).
//  FSM: BLEND -(frame_ready)-> DRAIN_RD -> DRAIN_WR -(!sd_waitrequest & last)-> DONE -> BLEND;
//       DRAIN_WR -(!sd_waitrequest & !last)-> DRAIN_RD; DRAIN_WR holds while sd_waitrequest=1.
//  BLEND: blend_write stores next edge; blend_read gives read_rdata/read_valid 1 clk later (registered RAM).
//   Same-cycle read+write to same index returns OLD data. Both may be high together.
//   pixel_number >= NUM_PIXELS: write dropped, read returns 0 with read_valid=1; drop_err set.
//  frame_ready with blend_write in same cycle: write accepted, DRAIN_RD next cycle.
//  DRAIN_RD: RAM read at drain index. DRAIN_WR: sd_write=1, sd_wdata={0,pixel}, sd_address=base+idx*(SD_DATA_W/8);
//   address/data/sd_write stable while sd_waitrequest=1; transfer completes on edge with sd_write&!sd_waitrequest.
//   Throughput >=2 clk/pixel; last = (idx==NUM_PIXELS-1); index cleared to 0 in DONE.
//  Non-BLEND states: blend_write/blend_read ignored (no read_valid), drop_err set; frame_ready ignored.
//  DONE: frame_done=1 for exactly one cycle, sd_write=0.
//  drop_err clears only on rst. Reset mid-drain: sd_write drops asynchronously, FSM to BLEND, index 0.
//  Address arithmetic SD_ADDR_W wide, wraps modulo 2^SD_ADDR_W (no saturation).
// CONFIGURATION
//  OUTCTRL_DBLBUF_EN defined: base register toggles SD_BASE <-> SD_BASE_B in DONE; first frame after reset uses SD_BASE;
//   extra output front_base[SD_ADDR_W] = base of last completed frame (reset SD_BASE_B).
//  Undefined: every frame written at SD_BASE; no front_base port.
// STRUCTURE
//  Package gpu_out_pkg: state enum out_state_t {BLEND,DRAIN_RD,DRAIN_WR,DONE}, pixel packing func, default constants.
//  One sub-module: frame_ram (simple dual-port, 1 write + 1 registered read port, parametrised width/depth).
//  Read port muxed: blender address in BLEND, drain index otherwise.
// TESTING (bench NUM_PIXELS=16, SD_BASE=0)
//  1 write px5=24'hAABBCC, read px5 next cycle -> read_valid 1 clk later, read_rdata=24'hAABBCC.
//  2 fill px0..15 with 24'h000010+i, frame_ready, waitrequest=0 -> 16 writes, addr 0x00..0x3C step 4,
//    wdata 32'h00000010+i, frame_done pulse once, busy low after.
//  3 as 2, waitrequest high 3 clk on pixel 7 -> sd_address=0x1C and sd_wdata held stable, no duplicate/skipped pixel.
//  4 blend_write during drain, and pixel_number=20 in BLEND -> RAM unchanged, drop_err=1 sticky.
//  5 rst asserted mid-drain at pixel 9 -> sd_write=0 immediately; new frame_ready restarts at address 0.
//  6 OUTCTRL_DBLBUF_EN: two frames -> first at 0x0, second at SD_BASE_B; front_base follows each frame_done.

Source files
------------

// File: rtl/gpu_out_pkg.sv
// Shared types and defaults for the SimpleGPU frame output stage.
// Optional double buffering is enabled by defining OUTCTRL_DBLBUF_EN.
package gpu_out_pkg;

  typedef enum logic [1:0] {
    BLEND,
    DRAIN_RD,
    DRAIN_WR,
    DONE
  } out_state_t;

  localparam int DEF_PIXEL_W    = 24;
  localparam int DEF_NUM_PIXELS = 76800;
  localparam int DEF_ADDR_W     = 17;
  localparam int DEF_SD_ADDR_W  = 26;
  localparam int DEF_SD_DATA_W  = 32;

  localparam logic [25:0] DEF_SD_BASE   = 26'h0;
  localparam logic [25:0] DEF_SD_BASE_B = 26'h80000;

  // Pack 8-bit channels into the {b,g,r} pixel layout.
  function automatic logic [23:0] pack_pixel(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {b, g, r};
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module frame_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Storage is left uninitialised; read is registered for block RAM mapping.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_output_ctrl.sv
// Frame buffer output stage: blender RAM access, then SDRAM drain.
// Define OUTCTRL_DBLBUF_EN to alternate frames between two SDRAM bases.
module frame_output_ctrl
  import gpu_out_pkg::*;
#(
  parameter int PIXEL_W    = DEF_PIXEL_W,
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SD_ADDR_W  = DEF_SD_ADDR_W,
  parameter int SD_DATA_W  = DEF_SD_DATA_W,
  parameter logic [SD_ADDR_W-1:0] SD_BASE =
    SD_ADDR_W'(DEF_SD_BASE)
`ifdef OUTCTRL_DBLBUF_EN
  ,
  parameter logic [SD_ADDR_W-1:0] SD_BASE_B =
    SD_ADDR_W'(DEF_SD_BASE_B)
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    pixel_number,
  input  logic                 blend_write,
  input  logic [PIXEL_W-1:0]   blend_wdata,
  input  logic                 blend_read,
  output logic [PIXEL_W-1:0]   read_rdata,
  output logic                 read_valid,
  input  logic                 frame_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 drop_err,
  output logic                 sd_write,
  output logic [SD_ADDR_W-1:0] sd_address,
  output logic [SD_DATA_W-1:0] sd_wdata,
  input  logic                 sd_waitrequest
`ifdef OUTCTRL_DBLBUF_EN
  ,
  output logic [SD_ADDR_W-1:0] front_base
`endif
);

  localparam int RAM_AW =
    (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [SD_ADDR_W-1:0] STRIDE =
    SD_ADDR_W'(SD_DATA_W / 8);
  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(NUM_PIXELS - 1);

  out_state_t r_state;
  out_state_t w_next;

  logic [ADDR_W-1:0]    r_idx;
  logic [SD_ADDR_W-1:0] w_base;
  logic                 r_rvalid;
  logic                 r_rzero;
  logic                 r_drop;

  logic                 w_blend;
  logic                 w_inr;
  logic                 w_we;
  logic                 w_last;
  logic                 w_sd_write;
  logic                 w_done;
  logic [RAM_AW-1:0]    w_raddr;
  logic [PIXEL_W-1:0]   w_rdata;

  assign w_blend = (r_state == BLEND);
  assign w_inr   = 32'(pixel_number) < 32'(NUM_PIXELS);
  assign w_we    = w_blend && blend_write && w_inr;
  assign w_last  = (r_idx == LAST_IDX);

  // Out-of-range blender reads are parked on word 0 and masked later.
  assign w_raddr = !w_blend ? r_idx[RAM_AW-1:0] :
                   w_inr    ? pixel_number[RAM_AW-1:0] :
                              '0;

  frame_ram #(
    .W     (PIXEL_W),
    .DEPTH (NUM_PIXELS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (pixel_number[RAM_AW-1:0]),
    .i_wdata (blend_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLEND;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next     = r_state;
    w_sd_write = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      BLEND: begin
        if (frame_ready) begin
          w_next = DRAIN_RD;
        end
      end
      DRAIN_RD: begin
        w_next = DRAIN_WR;
      end
      DRAIN_WR: begin
        w_sd_write = 1'b1;
        if (!sd_waitrequest) begin
          w_next = w_last ? DONE : DRAIN_RD;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = BLEND;
      end
      default: begin
        w_next = BLEND;
      end
    endcase
  end

  // Drain index advances per accepted SDRAM word, clears after frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (r_state == DRAIN_WR &&
                 !sd_waitrequest && !w_last) begin
      r_idx <= r_idx + 1'b1;
    end else if (r_state == DONE) begin
      r_idx <= '0;
    end
  end

`ifdef OUTCTRL_DBLBUF_EN
  logic [SD_ADDR_W-1:0] r_base;
  logic [SD_ADDR_W-1:0] r_front;

  // Swap back/front SDRAM buffers as each frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base  <= SD_BASE;
      r_front <= SD_BASE_B;
    end else if (r_state == DONE) begin
      r_front <= r_base;
      r_base  <= (r_base == SD_BASE) ? SD_BASE_B : SD_BASE;
    end
  end

  assign w_base     = r_base;
  assign front_base = r_front;
`else
  assign w_base = SD_BASE;
`endif

  // Blender read response and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rzero  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_rvalid <= w_blend && blend_read;
      r_rzero  <= !w_inr;
      if ((blend_write || blend_read) &&
          (!w_blend || !w_inr)) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign read_valid = r_rvalid;
  assign read_rdata = (r_rvalid && !r_rzero) ? w_rdata : '0;
  assign drop_err   = r_drop;
  assign busy       = !w_blend;
  assign frame_done = w_done;
  assign sd_write   = w_sd_write;
  assign sd_address = w_sd_write ?
                      w_base + SD_ADDR_W'(r_idx) * STRIDE : '0;
  assign sd_wdata   = w_sd_write ? SD_DATA_W'(w_rdata) : '0;

endmodule
